// File: rtl/riscv_pkg.sv
// riscv_pkg: encodings shared by the multicycle control unit.
//   - Opcode constants for the supported instruction classes.
//   - Main FSM state enum (4-bit encoding).
//   - ALUOp / ALUSrcA / ALUSrcB / ResultSrc select encodings.
//     ALU_decoder uses the same ALUOp values.
//   - op_supported(): true for every opcode the main FSM can execute.
package riscv_pkg;

    // Opcodes (instr[6:0])
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpRType = 7'b0110011;
    localparam logic [6:0] OpIAlu  = 7'b0010011;
    localparam logic [6:0] OpBeq   = 7'b1100011;
    localparam logic [6:0] OpJal   = 7'b1101111;

    // ALUOp, consumed by ALU_decoder
    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    // ALU operand A select
    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARs1   = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SrcBRs2    = 2'b00;
    localparam logic [1:0] SrcBImmExt = 2'b01;
    localparam logic [1:0] SrcBFour   = 2'b10;

    // Result mux select
    localparam logic [1:0] ResAluOut    = 2'b00;
    localparam logic [1:0] ResData      = 2'b01;
    localparam logic [1:0] ResAluResult = 2'b10;

    // Address mux select
    localparam logic AdrPc     = 1'b0;
    localparam logic AdrResult = 1'b1;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecuteR = 4'd6,
        StExecuteI = 4'd7,
        StJal      = 4'd8,
        StAluWb    = 4'd9,
        StBeq      = 4'd10
    } main_state_e;

    function automatic logic op_supported(logic [6:0] op);
        unique case (op)
            OpLoad, OpStore, OpRType, OpIAlu, OpBeq, OpJal: op_supported = 1'b1;
            default:                                        op_supported = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/main_fsm.sv
// main_fsm: multicycle main controller of the RISC-V control unit.
// Steps fetch / decode / execute / writeback and drives the datapath selects
// and strobes. Outputs are decoded from the state register, except that the
// FETCH strobes follow mem_ready and MEMWRITE completes on mem_ready.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset; forces all outputs to 0
//   op         in   opcode from the instruction register (instr[6:0])
//   mem_ready  in   memory completes the current access this cycle
//   ALUOp      out  ALU_decoder control: add / sub-compare / funct-decoded
//   ALUSrcA    out  operand A: PC / OldPC / rs1
//   ALUSrcB    out  operand B: rs2 / ImmExt / 4
//   ResultSrc  out  result: ALUOut / Data / ALUResult
//   AdrSrc     out  memory address: PC / Result
//   IRWrite, PCUpdate, Branch, RegWrite, MemWrite  out  datapath strobes
//   instr_done out  pulse in the final cycle of every instruction
//   illegal_op out  pulse when DECODE sees an unsupported opcode
module main_fsm
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCUpdate,
    output logic       Branch,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       instr_done,
    output logic       illegal_op
);

    main_state_e state_q, state_d;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch: begin
                if (mem_ready) state_d = StDecode;
            end
            StDecode: begin
                unique case (op)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRType:         state_d = StExecuteR;
                    OpIAlu:          state_d = StExecuteI;
                    OpBeq:           state_d = StBeq;
                    OpJal:           state_d = StJal;
                    default:         state_d = StFetch;
                endcase
            end
            StMemAdr: begin
                // op is held stable by the IR, so only lw/sw can arrive here.
                if (op == OpLoad) begin
                    state_d = StMemRead;
                end else if (op == OpStore) begin
                    state_d = StMemWrite;
                end else begin
                    state_d = StFetch;
                end
            end
            StMemRead: begin
                if (mem_ready) state_d = StMemWb;
            end
            StMemWrite: begin
                if (mem_ready) state_d = StFetch;
            end
            StMemWb:    state_d = StFetch;
            StExecuteR: state_d = StAluWb;
            StExecuteI: state_d = StAluWb;
            StJal:      state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StBeq:      state_d = StFetch;
            default:    state_d = StFetch;
        endcase
    end

    // Output decode
    always_comb begin
        ALUOp      = AluOpAdd;
        ALUSrcA    = SrcAPc;
        ALUSrcB    = SrcBRs2;
        ResultSrc  = ResAluOut;
        AdrSrc     = AdrPc;
        IRWrite    = 1'b0;
        PCUpdate   = 1'b0;
        Branch     = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        instr_done = 1'b0;
        illegal_op = 1'b0;

        // Reset masks everything so an interrupted write never reaches the datapath.
        if (rst_n) begin
            unique case (state_q)
                StFetch: begin
                    AdrSrc    = AdrPc;
                    ALUSrcA   = SrcAPc;
                    ALUSrcB   = SrcBFour;
                    ALUOp     = AluOpAdd;
                    ResultSrc = ResAluResult;
                    // Only latch IR / advance PC when the fetch actually returns.
                    IRWrite   = mem_ready;
                    PCUpdate  = mem_ready;
                end
                StDecode: begin
                    ALUSrcA    = SrcAOldPc;
                    ALUSrcB    = SrcBImmExt;
                    ALUOp      = AluOpAdd;
                    illegal_op = !op_supported(op);
                end
                StMemAdr: begin
                    ALUSrcA = SrcARs1;
                    ALUSrcB = SrcBImmExt;
                    ALUOp   = AluOpAdd;
                end
                StMemRead: begin
                    ResultSrc = ResAluOut;
                    AdrSrc    = AdrResult;
                end
                StMemWb: begin
                    ResultSrc  = ResData;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                StMemWrite: begin
                    ResultSrc  = ResAluOut;
                    AdrSrc     = AdrResult;
                    MemWrite   = 1'b1;
                    instr_done = mem_ready;
                end
                StExecuteR: begin
                    ALUSrcA = SrcARs1;
                    ALUSrcB = SrcBRs2;
                    ALUOp   = AluOpFunct;
                end
                StExecuteI: begin
                    ALUSrcA = SrcARs1;
                    ALUSrcB = SrcBImmExt;
                    ALUOp   = AluOpFunct;
                end
                StJal: begin
                    ALUSrcA   = SrcAOldPc;
                    ALUSrcB   = SrcBFour;
                    ALUOp     = AluOpAdd;
                    ResultSrc = ResAluOut;
                    PCUpdate  = 1'b1;
                end
                StAluWb: begin
                    ResultSrc  = ResAluOut;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                StBeq: begin
                    ALUSrcA    = SrcARs1;
                    ALUSrcB    = SrcBRs2;
                    ALUOp      = AluOpSub;
                    ResultSrc  = ResAluOut;
                    Branch     = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/main_fsm.md
# main_fsm

Multicycle main controller FSM for the RISC-V core's control unit. It decodes the 7-bit opcode held in the instruction register and steps through fetch/decode/execute/writeback states. Each cycle it drives the datapath enables and the 2-bit `ALUOp` consumed directly by `ALU_decoder`. A `mem_ready` handshake stretches memory-access states; `PCWrite` is formed outside (`PCUpdate | (Branch & Zero)`).

## Interface
- No parameters; all encodings come from the shared package.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous, active-low reset
- `op`  in  7  opcode from instruction register (`instr[6:0]`)
- `mem_ready`  in  1  memory completes the current access this cycle
- `ALUOp`  out  2  to `ALU_decoder`: 00 add, 01 sub/compare, 10 funct-decoded
- `ALUSrcA`  out  2  00 PC, 01 OldPC, 10 rs1 data
- `ALUSrcB`  out  2  00 rs2 data, 01 ImmExt, 10 constant 4
- `ResultSrc`  out  2  00 ALUOut, 01 Data, 10 ALUResult
- `AdrSrc`  out  1  0 PC, 1 Result
- `IRWrite`, `PCUpdate`, `Branch`, `RegWrite`, `MemWrite`  out  1 each  datapath strobes
- `instr_done`  out  1  one-cycle pulse in the final state of every instruction
- `illegal_op`  out  1  one-cycle pulse when DECODE sees an unsupported opcode

## Operation
- Opcodes: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
- Moore outputs decode from the state register. Exceptions: `IRWrite`/`PCUpdate` in FETCH are gated by `mem_ready`.
- Unlisted outputs are 0.
- FETCH: AdrSrc 0, ALUSrcA 00, ALUSrcB 10, ALUOp 00, ResultSrc 10, IRWrite=PCUpdate=`mem_ready`. Go to DECODE on `mem_ready`, else hold.
- DECODE: ALUSrcA 01, ALUSrcB 01, ALUOp 00. Next state by opcode:
  - lw/sw → MEMADR; R → EXECUTER; I → EXECUTEI; beq → BEQ; jal → JAL.
  - Any other opcode → FETCH with `illegal_op`=1.
- MEMADR: ALUSrcA 10, ALUSrcB 01, ALUOp 00. lw → MEMREAD; sw → MEMWRITE.
- MEMREAD: ResultSrc 00, AdrSrc 1. Hold until `mem_ready`, then MEMWB.
- MEMWB: ResultSrc 01, RegWrite 1, `instr_done`. Next FETCH.
- MEMWRITE: ResultSrc 00, AdrSrc 1, MemWrite 1 for every waiting cycle. On `mem_ready`: `instr_done`, then FETCH.
- EXECUTER: ALUSrcA 10, ALUSrcB 00, ALUOp 10. Next ALUWB.
- EXECUTEI: ALUSrcA 10, ALUSrcB 01, ALUOp 10. Next ALUWB.
- JAL: ALUSrcA 01, ALUSrcB 10, ALUOp 00, ResultSrc 00, PCUpdate 1. Next ALUWB.
- ALUWB: ResultSrc 00, RegWrite 1, `instr_done`. Next FETCH.
- BEQ: ALUSrcA 10, ALUSrcB 00, ALUOp 01, ResultSrc 00, Branch 1, `instr_done`. Next FETCH.
- `op` is sampled only in DECODE and MEMADR. It is stable from FETCH completion onward because the IR is written only there.

## Timing
- Reset: while `rst_n`=0 at a rising edge, state ← FETCH. While `rst_n` is low, every output is forced to 0, including `ALUOp`=00.
- Reset has priority over `mem_ready` and applies mid-instruction: an in-flight MemWrite/RegWrite is dropped.
- Cycles with `mem_ready` tied 1:
  - R/I/jal/lw: 4 / 4 / 4 / 5 cycles.
  - sw and beq: 4 and 3 cycles.
- Each cycle `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. No strobe fires twice per instruction.
- Illegal opcode: 2 cycles (FETCH, DECODE), no writes, `illegal_op` during DECODE.
- `instr_done` and `illegal_op` are never high in the same cycle.

## Structure
- Shared package `riscv_pkg`: opcode constants, state enum (4-bit encoding), and the ALUOp/ALUSrcA/ALUSrcB/ResultSrc encodings. `ALU_decoder` imports the same ALUOp values.
- Single module: next-state logic, state register, and output decode. No sub-module.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `mem_ready`=1 → all outputs 0. After release, state is FETCH, IRWrite=1, ALUSrcB=10.
- `op`=0110011, `mem_ready`=1 → FETCH, DECODE, EXECUTER (ALUOp 10, ALUSrcB 00), ALUWB (RegWrite 1, `instr_done`) → back to FETCH.
- lw with `mem_ready` low for 2 cycles in MEMREAD → 7-cycle instruction. MEMWB is reached once, with ResultSrc 01 and a single RegWrite pulse.
- sw with `mem_ready`=0 for 1 cycle → MemWrite high for 2 consecutive cycles, then FETCH. RegWrite is never set.
- beq → BEQ cycle has ALUOp 01 and Branch 1, 3 cycles total. jal → JAL cycle has PCUpdate 1 and ALUSrcB 10, followed by ALUWB.
- `op`=1111111 → `illegal_op` pulse in DECODE, return to FETCH, no RegWrite/MemWrite. Separately, assert `rst_n`=0 during MEMWRITE → MemWrite drops that cycle, and FETCH follows.
